iter_multdiv_unit: RTL and testbench
====================================

// Module: iter_multdiv_unit
// PURPOSE
//   Iterative signed multiply/divide responder on the pipeline's multdiv handshake.
//   The pipeline pulses ctrl_MULT or ctrl_DIV for one cycle with operands valid.
//   This block latches the operands and computes the result over many cycles.
//   It then returns the result with a one-cycle data_resultRDY pulse and an exception flag.
//   Sits beside the execute-stage ALU; the pipeline stalls on busy and writes back when data_resultRDY is high.
// PARAMETERS
//   WIDTH      32  operand/result width in bits; must be even and >= 4
// PORTS
//   clock           in   1      master clock; all state updates on rising edge
//   reset           in   1      asynchronous, active-high reset
//   data_operandA   in   WIDTH  multiplicand / dividend (two's complement)
//   data_operandB   in   WIDTH  multiplier / divisor (two's complement)
//   ctrl_MULT       in   1      start-multiply request, sampled every rising edge
//   ctrl_DIV        in   1      start-divide request, sampled every rising edge
//   data_result     out  WIDTH  low WIDTH bits of product, or quotient
//   data_exception  out  1      overflow / divide-by-zero flag for data_result
//   data_resultRDY  out  1      one-cycle pulse: data_result/data_exception valid
//   busy            out  1      high while an operation is in progress
// BEHAVIOUR
// - Reset (async, any time, including mid-operation):
//   - state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0.
//   - Any in-flight operation is discarded; no RDY pulse follows.
// - FSM states:
//   - IDLE --start--> MULT or DIV.
//   - MULT --count==WIDTH/2--> DONE.
//   - DIV --count==WIDTH--> DONE.
//   - DONE --next edge--> IDLE.
// - Start:
//   - At edge E0 with ctrl_MULT or ctrl_DIV high, latch both operands and clear the step counter.
//   - Enter MULT or DIV; busy=1 from E0.
//   - Both ctrl high at once: MULT wins.
//   - Start is accepted in ANY state and aborts the current operation: no RDY for the aborted op, counter restarts.
// - MULT: radix-4 Booth.
//   - One step per edge, 2*WIDTH+1-bit product/multiplier register.
//   - WIDTH/2 steps at edges E1..E(WIDTH/2).
// - DIV: restoring division on operand magnitudes.
//   - One quotient bit per edge over WIDTH steps at edges E1..E(WIDTH).
//   - Final step applies sign: quotient negated iff sign(A) xor sign(B).
//   - Truncation is toward zero; remainder is not output.
// - Completion:
//   - On the edge of the final step, register data_result and data_exception.
//   - On that same edge set data_resultRDY=1, busy=0, state=DONE.
//   - RDY drops at the next edge.
//   - Latency: RDY high in the cycle after edge E(WIDTH/2) for mult, E(WIDTH) for div.
// - Hold: data_result/data_exception keep their values after RDY until the next completion.
//   A new start does not clear them.
// - Exceptions:
//   - MULT: data_exception=1 iff the 2*WIDTH product is not the sign-extension of its low WIDTH bits.
//     data_result = low WIDTH bits regardless.
//   - DIV by zero: data_result=0, data_exception=1, same latency as a normal divide.
//   - DIV of most-negative by -1: data_result=most-negative (0x80000000 at WIDTH=32), data_exception=1.
// - Operands are not re-sampled after E0; input changes during an operation have no effect.
// TESTING
// 1. A=7, B=-6 (0xFFFFFFFA), ctrl_MULT pulse -> RDY exactly 16 cycles later, result=0xFFFFFFD6, exc=0.
// 2. A=0x00010000, B=0x00010000, MULT -> result=0x00000000, exc=1; A=0x80000000,B=1 -> 0x80000000, exc=0.
// 3. A=-7, B=2, ctrl_DIV -> RDY 32 cycles later, result=0xFFFFFFFD (-3), exc=0; A=100,B=-7 -> -14.
// 4. A=5, B=0, DIV -> result=0, exc=1 at 32 cycles; A=0x80000000,B=-1 -> 0x80000000, exc=1.
// 5. MULT 3*4 started, DIV 100/7 pulsed 5 cycles later -> single RDY 32 cycles after second start, result=14.
// 6. Start DIV, assert reset at cycle 10 -> all outputs 0 immediately, no RDY ever; both ctrl high -> mult.

Source files
------------

// File: rtl/iter_multdiv_unit.sv
// Iterative signed multiply/divide unit: radix-4 Booth multiply (WIDTH/2 steps) and
// restoring divide on magnitudes (WIDTH steps), with a one-cycle result-ready pulse.
module iter_multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t state, state_next;

    logic start;
    logic mult_last, div_last;
    logic [CW-1:0] count;

    // Booth register layout: {hi[WIDTH-1:0], lo[WIDTH-1:0], x}
    logic signed [WIDTH-1:0]   mcand;
    logic        [2*WIDTH:0]   prod;
    logic signed [WIDTH+1:0]   booth_sum;
    logic        [2*WIDTH:0]   prod_step;
    logic                      mult_exc;

    logic [WIDTH-1:0] div_mag, rem, quo;
    logic             quo_neg, div_zero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [WIDTH:0]   div_out;

    function automatic logic signed [WIDTH+1:0] booth_addend(input logic [2:0] bits,
                                                             input logic signed [WIDTH-1:0] m);
        logic signed [WIDTH+1:0] m_ext;
        m_ext = {{2{m[WIDTH-1]}}, m};
        case (bits)
            3'b001, 3'b010: return m_ext;
            3'b011:         return m_ext <<< 1;
            3'b100:         return -(m_ext <<< 1);
            3'b101, 3'b110: return -m_ext;
            default:        return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] a);
        return a[WIDTH-1] ? -a : a;
    endfunction

    // Returns {exception, quotient}; the only positive overflow is most-negative / -1.
    function automatic logic [WIDTH:0] div_finish(input logic [WIDTH-1:0] q,
                                                  input logic neg, input logic zero);
        if (zero)
            return {1'b1, {WIDTH{1'b0}}};
        else if (neg)
            return {1'b0, -q};
        else
            return {q[WIDTH-1], q};
    endfunction

    assign start     = ctrl_MULT | ctrl_DIV;
    assign mult_last = (state == MULT) && (count == CW'(WIDTH/2 - 1));
    assign div_last  = (state == DIV)  && (count == CW'(WIDTH - 1));

    assign booth_sum = {{2{prod[2*WIDTH]}}, prod[2*WIDTH:WIDTH+1]} + booth_addend(prod[2:0], mcand);
    assign prod_step = {booth_sum, prod[WIDTH:2]};
    assign mult_exc  = prod_step[2*WIDTH:WIDTH+1] != {WIDTH{prod_step[WIDTH]}};

    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, div_mag};
    assign rem_next = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
    assign div_out  = div_finish(quo_next, quo_neg, div_zero);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (state)
            MULT: begin
                busy = 1'b1;
                if (mult_last) state_next = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (div_last) state_next = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A new request always wins, aborting whatever is in flight.
        if (start)
            state_next = ctrl_MULT ? MULT : DIV;
    end

    always_ff @(posedge clock) begin
        if (start) begin
            mcand    <= data_operandA;
            prod     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            quo      <= magnitude(data_operandA);
            div_mag  <= magnitude(data_operandB);
            rem      <= '0;
            quo_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            count    <= '0;
        end else begin
            if (state == MULT)
                prod <= prod_step;
            if (state == DIV) begin
                rem <= rem_next;
                quo <= quo_next;
            end
            if (busy)
                count <= count + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (!start) begin
            if (mult_last) begin
                data_result    <= prod_step[WIDTH:1];
                data_exception <= mult_exc;
            end else if (div_last) begin
                data_result    <= div_out[WIDTH-1:0];
                data_exception <= div_out[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_iter_multdiv_unit.sv
// Directed-vector bench for iter_multdiv_unit at WIDTH=32.
module tb_iter_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] prev_res = '0;
    logic        prev_exc = 1'b0;

    iter_multdiv_unit #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse the request for one edge, then scramble the operands.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        start_op(m, d, a, b);
        check_val({tag, ".busy"}, 64'(busy), 64'(1));
        check_val({tag, ".hold_res"}, 64'(data_result), 64'(prev_res));
        check_val({tag, ".hold_exc"}, 64'(data_exception), 64'(prev_exc));
        wait_rdy(lat);
        check_val({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, ".res"}, 64'(data_result), 64'(exp_res));
        check_val({tag, ".exc"}, 64'(data_exception), 64'(exp_exc));
        check_val({tag, ".busy_done"}, 64'(busy), 64'(0));
        @(negedge clock);
        check_val({tag, ".rdy_drop"}, 64'(data_resultRDY), 64'(0));
        check_val({tag, ".res_kept"}, 64'(data_result), 64'(exp_res));
        prev_res = exp_res;
        prev_exc = exp_exc;
    endtask

    initial begin
        int first_lat;
        int rdy_cnt;

        #12;
        check_val("rst.res", 64'(data_result), 64'(0));
        check_val("rst.exc", 64'(data_exception), 64'(0));
        check_val("rst.rdy", 64'(data_resultRDY), 64'(0));
        check_val("rst.busy", 64'(busy), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        run_op("mul_7x-6", 1, 0, 32'd7, 32'hFFFF_FFFA, 16, 32'hFFFF_FFD6, 0);
        run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 16, 32'h0000_0000, 1);
        run_op("mul_min", 1, 0, 32'h8000_0000, 32'd1, 16, 32'h8000_0000, 0);
        run_op("mul_negneg", 1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 16, 32'd15, 0);
        run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD, 0);
        run_op("div_100/-7", 0, 1, 32'd100, 32'hFFFF_FFF9, 32, 32'hFFFF_FFF2, 0);
        run_op("div_by0", 0, 1, 32'd5, 32'd0, 32, 32'd0, 1);
        run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h8000_0000, 1);
        run_op("div_-100/-7", 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32, 32'd14, 0);

        // Multiply aborted five cycles in by a divide: exactly one pulse, for the divide.
        start_op(1, 0, 32'd3, 32'd4);
        repeat (3) @(negedge clock);
        start_op(0, 1, 32'd100, 32'd7);
        first_lat = -1;
        rdy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                rdy_cnt++;
                if (first_lat < 0) begin
                    first_lat = n;
                    check_val("abort.res", 64'(data_result), 64'(14));
                    check_val("abort.exc", 64'(data_exception), 64'(0));
                end
            end
        end
        check_val("abort.rdy_count", 64'(rdy_cnt), 64'(1));
        check_val("abort.lat", 64'(first_lat), 64'(32));
        prev_res = 32'd14;
        prev_exc = 1'b0;

        // Async reset mid-divide discards the operation and clears the outputs at once.
        start_op(0, 1, 32'd100, 32'd7);
        repeat (9) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst.res", 64'(data_result), 64'(0));
        check_val("arst.exc", 64'(data_exception), 64'(0));
        check_val("arst.busy", 64'(busy), 64'(0));
        check_val("arst.rdy", 64'(data_resultRDY), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        rdy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        check_val("arst.no_rdy", 64'(rdy_cnt), 64'(0));
        check_val("arst.res_after", 64'(data_result), 64'(0));
        prev_res = '0;
        prev_exc = 1'b0;

        run_op("both_ctrl", 1, 1, 32'd3, 32'd4, 16, 32'd12, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
